// File: rtl/shift_rotate_sequencer.sv
// shift_rotate_sequencer
//   Multi-cycle variable shift/rotate unit. A single 16-bit datapath stage is
//   run four times. The step on iteration k is 2^k bits, applied only when
//   bit k of the latched count is set. Valid/ready handshakes on both sides
//   let the surrounding pipeline stall on it.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   request valid
//   in_ready   block can accept a request (high only in IDLE)
//   in_data    16-bit operand
//   in_cnt     shift/rotate amount, 0-15
//   in_op      00 ROL, 01 SLL, 10 ROR, 11 SRL
//   out_valid  result valid (high in DONE)
//   out_ready  consumer accepts result
//   out_data   result, held until the next result is written
//   busy       high in SHIFT or DONE
//
// Parameters
//   FAST_ZERO  when 1, a count of 0 skips SHIFT and goes straight to DONE

module shift_rotate_sequencer #(
  parameter bit FAST_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [3:0]  in_cnt,
  input  logic [1:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [1:0] OpRol = 2'b00;
  localparam logic [1:0] OpSll = 2'b01;
  localparam logic [1:0] OpRor = 2'b10;
  localparam logic [1:0] OpSrl = 2'b11;

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [15:0] work_q, work_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] out_data_q, out_data_d;
  logic [15:0] step_res;

  // One datapath stage: move w by s bits according to op.
  function automatic logic [15:0] shift_step(input logic [15:0] w, input logic [1:0] op,
                                             input logic [4:0] s);
    logic [31:0] dbl;
    logic [15:0] res;
    dbl = 32'd0;
    res = w;
    unique case (op)
      OpRol: begin
        dbl = {w, w} << s;
        res = dbl[31:16];
      end
      OpSll: res = w << s;
      OpRor: begin
        dbl = {w, w} >> s;
        res = dbl[15:0];
      end
      OpSrl: res = w >> s;
      default: res = w;
    endcase
    return res;
  endfunction

  // Stage k moves by 2^k only when the matching count bit is set.
  always_comb begin
    step_res = work_q;
    if (cnt_q[k_q]) begin
      step_res = shift_step(work_q, op_q, 5'd1 << k_q);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      k_q        <= 2'd0;
      work_q     <= 16'd0;
      cnt_q      <= 4'd0;
      op_q       <= 2'd0;
      out_data_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      out_data_q <= out_data_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    out_data_d = out_data_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          work_d = in_data;
          cnt_d  = in_cnt;
          op_d   = in_op;
          k_d    = 2'd0;
          if (FAST_ZERO && (in_cnt == 4'd0)) begin
            out_data_d = in_data;
            state_d    = StDone;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        work_d = step_res;
        k_d    = k_q + 2'd1;
        if (k_q == 2'd3) begin
          out_data_d = step_res;
          state_d    = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode straight from the state register so reset drops them at once.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    out_data  = out_data_q;
  end

endmodule
